// File: rtl/sc_regpointrot_pkg.sv
// Shared encodings for the rotating point register: step modes and ping-pong states.
package sc_regpointrot_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_ROTL     = 2'b01,
    MODE_ROTR     = 2'b10,
    MODE_PINGPONG = 2'b11
  } modeT;

  typedef enum logic {
    PP_LEFT  = 1'b0,
    PP_RIGHT = 1'b1
  } ppStateT;

endpackage

// File: rtl/sc_regpointrot_prescaler.sv
// Auto-step prescaler: counts 0..period and raises tick on the terminal count.
module sc_regpointrot_prescaler #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          restart,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] countReg;

  assign tick = enable && (countReg == period);

  // Counter restarts on clear/load, idles at zero when disabled, wraps after tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg <= {PW{1'b0}};
    end else if (restart || !enable || tick) begin
      countReg <= {PW{1'b0}};
    end else begin
      countReg <= countReg + {{(PW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sc_regpointrot.sv
// Rotating point register with multi-bit rotate, ping-pong bounce and auto-step timer.
// Optional logical-shift mode is enabled with `define SC_REGPOINTROT_LOGICAL_SHIFT_EN.
module sc_regpointrot
  import sc_regpointrot_pkg::*;
#(
  parameter int REGPOINTROT_DATAWIDTH     = 8,
  parameter int REGPOINTROT_AMTWIDTH      = 3,
  parameter int REGPOINTROT_PRESCALEWIDTH = 4,
  parameter logic [REGPOINTROT_DATAWIDTH-1:0] DATA_FIXED_INITREGPOINT = 8'b00000001
) (
  input  logic                                 SC_RegPOINTROT_CLOCK_50,
  input  logic                                 SC_RegPOINTROT_RESET_InHigh,
  input  logic                                 SC_RegPOINTROT_clear_InLow,
  input  logic                                 SC_RegPOINTROT_load_InLow,
  input  logic [REGPOINTROT_DATAWIDTH-1:0]     SC_RegPOINTROT_data_InBUS,
  input  logic [1:0]                           SC_RegPOINTROT_mode_In,
  input  logic [REGPOINTROT_AMTWIDTH-1:0]      SC_RegPOINTROT_amount_In,
  input  logic                                 SC_RegPOINTROT_step_InLow,
  input  logic                                 SC_RegPOINTROT_autostep_en_In,
  input  logic [REGPOINTROT_PRESCALEWIDTH-1:0] SC_RegPOINTROT_prescale_In,
`ifdef SC_REGPOINTROT_LOGICAL_SHIFT_EN
  input  logic                                 SC_RegPOINTROT_shiftmode_In,
  input  logic                                 SC_RegPOINTROT_fill_In,
`endif
  output logic [REGPOINTROT_DATAWIDTH-1:0]     SC_RegPOINTROT_data_OutBUS,
  output logic [REGPOINTROT_AMTWIDTH-1:0]      SC_RegPOINTROT_position_OutBUS,
  output logic                                 SC_RegPOINTROT_dir_Out,
  output logic                                 SC_RegPOINTROT_wrap_OutHigh
);

  localparam int W = REGPOINTROT_DATAWIDTH;
  localparam int A = REGPOINTROT_AMTWIDTH;

  logic [W-1:0] dataReg;
  logic [A-1:0] posReg;
  ppStateT      ppState;
  logic         wrapReg;

  logic         tick;
  logic         stepEvent;
  logic         restart;
  logic         logicalSel;
  logic         fillSel;
  logic [W-1:0] leftData;
  logic [W-1:0] rightData;
  logic [A:0]   posSum;
  logic [W-1:0] stepData;
  logic [A-1:0] stepPos;
  ppStateT      stepState;
  logic         stepWrap;

`ifdef SC_REGPOINTROT_LOGICAL_SHIFT_EN
  assign logicalSel = SC_RegPOINTROT_shiftmode_In;
  assign fillSel    = SC_RegPOINTROT_fill_In;
`else
  assign logicalSel = 1'b0;
  assign fillSel    = 1'b0;
`endif

  function automatic logic [W-1:0] moveLeft(input logic [W-1:0] d, input logic [A-1:0] amt,
                                            input logic logical, input logic fill);
    logic [2*W-1:0] wide;
    logic [W-1:0]   vacated;
    wide    = {d, d} << amt;
    vacated = ~({W{1'b1}} << amt);
    if (logical) begin
      moveLeft = (d << amt) | (fill ? vacated : {W{1'b0}});
    end else begin
      moveLeft = wide[2*W-1:W];
    end
  endfunction

  function automatic logic [W-1:0] moveRight(input logic [W-1:0] d, input logic [A-1:0] amt,
                                             input logic logical, input logic fill);
    logic [2*W-1:0] wide;
    logic [W-1:0]   vacated;
    wide    = {d, d} >> amt;
    vacated = ~({W{1'b1}} >> amt);
    if (logical) begin
      moveRight = (d >> amt) | (fill ? vacated : {W{1'b0}});
    end else begin
      moveRight = wide[W-1:0];
    end
  endfunction

  assign restart   = !SC_RegPOINTROT_clear_InLow || !SC_RegPOINTROT_load_InLow;
  assign stepEvent = !SC_RegPOINTROT_step_InLow || tick;
  assign leftData  = moveLeft(dataReg, SC_RegPOINTROT_amount_In, logicalSel, fillSel);
  assign rightData = moveRight(dataReg, SC_RegPOINTROT_amount_In, logicalSel, fillSel);

  sc_regpointrot_prescaler #(
    .PW(REGPOINTROT_PRESCALEWIDTH)
  ) uPrescaler (
    .clk     (SC_RegPOINTROT_CLOCK_50),
    .rst     (SC_RegPOINTROT_RESET_InHigh),
    .enable  (SC_RegPOINTROT_autostep_en_In),
    .restart (restart),
    .period  (SC_RegPOINTROT_prescale_In),
    .tick    (tick)
  );

  // Next-state of a single step; the carry of posSum marks a left overflow past W-1.
  always_comb begin
    posSum    = {1'b0, posReg} + {1'b0, SC_RegPOINTROT_amount_In};
    stepData  = dataReg;
    stepPos   = posReg;
    stepState = ppState;
    stepWrap  = 1'b0;
    case (modeT'(SC_RegPOINTROT_mode_In))
      MODE_HOLD: begin
        stepWrap = 1'b0;
      end
      MODE_ROTL: begin
        stepData = leftData;
        stepPos  = posSum[A-1:0];
        stepWrap = posSum[A];
      end
      MODE_ROTR: begin
        stepData = rightData;
        stepPos  = posReg - SC_RegPOINTROT_amount_In;
        stepWrap = (SC_RegPOINTROT_amount_In > posReg);
      end
      MODE_PINGPONG: begin
        if (ppState == PP_LEFT) begin
          if (!posSum[A]) begin
            stepData = leftData;
            stepPos  = posSum[A-1:0];
          end else begin
            stepState = PP_RIGHT;
            stepWrap  = 1'b1;
          end
        end else begin
          if (posReg >= SC_RegPOINTROT_amount_In) begin
            stepData = rightData;
            stepPos  = posReg - SC_RegPOINTROT_amount_In;
          end else begin
            stepState = PP_LEFT;
            stepWrap  = 1'b1;
          end
        end
      end
      default: begin
        stepWrap = 1'b0;
      end
    endcase
  end

  // Register update with clear > load > step priority; wrap lasts one cycle.
  always_ff @(posedge SC_RegPOINTROT_CLOCK_50 or posedge SC_RegPOINTROT_RESET_InHigh) begin
    if (SC_RegPOINTROT_RESET_InHigh) begin
      dataReg <= {W{1'b0}};
      posReg  <= {A{1'b0}};
      ppState <= PP_LEFT;
      wrapReg <= 1'b0;
    end else if (!SC_RegPOINTROT_clear_InLow) begin
      dataReg <= DATA_FIXED_INITREGPOINT;
      posReg  <= {A{1'b0}};
      ppState <= PP_LEFT;
      wrapReg <= 1'b0;
    end else if (!SC_RegPOINTROT_load_InLow) begin
      dataReg <= SC_RegPOINTROT_data_InBUS;
      posReg  <= {A{1'b0}};
      ppState <= PP_LEFT;
      wrapReg <= 1'b0;
    end else if (stepEvent) begin
      dataReg <= stepData;
      posReg  <= stepPos;
      ppState <= stepState;
      wrapReg <= stepWrap;
    end else begin
      wrapReg <= 1'b0;
    end
  end

  assign SC_RegPOINTROT_data_OutBUS     = dataReg;
  assign SC_RegPOINTROT_position_OutBUS = posReg;
  assign SC_RegPOINTROT_dir_Out         = (ppState == PP_RIGHT);
  assign SC_RegPOINTROT_wrap_OutHigh    = wrapReg;

endmodule

// File: doc/sc_regpointrot.md
Name: sc_regpointrot

Overview:
Parametrised rotating point register. It is the next generation of the single-step left/right rotate register.
- Adds multi-bit rotate amount, a ping-pong (bounce) mode and a built-in prescaled auto-step timer.
- Tracks the accumulated rotation offset and flags wrap-around.
- Sits between the point state machine and the display/matrix driver, producing the moving-point pattern.

Parameters:
- REGPOINTROT_DATAWIDTH, 8, register width W; power of two, at least 4.
- REGPOINTROT_AMTWIDTH, 3, width of amount/position; must equal clog2(W).
- REGPOINTROT_PRESCALEWIDTH, 4, width of the auto-step prescaler.
- DATA_FIXED_INITREGPOINT, 8'b00000001, value loaded on clear.

Ports:
- SC_RegPOINTROT_CLOCK_50  in  1  system clock, rising edge.
- SC_RegPOINTROT_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_RegPOINTROT_clear_InLow  in  1  synchronous clear to init value.
- SC_RegPOINTROT_load_InLow  in  1  synchronous parallel load.
- SC_RegPOINTROT_data_InBUS  in  W  load data.
- SC_RegPOINTROT_mode_In  in  2  00 hold, 01 rotate left, 10 rotate right, 11 ping-pong.
- SC_RegPOINTROT_amount_In  in  AMTWIDTH  positions moved per step (0 to W-1).
- SC_RegPOINTROT_step_InLow  in  1  manual step; one step per cycle held low.
- SC_RegPOINTROT_autostep_en_In  in  1  enables the prescaled auto-step.
- SC_RegPOINTROT_prescale_In  in  PRESCALEWIDTH  auto-step period minus 1.
- SC_RegPOINTROT_data_OutBUS  out  W  register contents.
- SC_RegPOINTROT_position_OutBUS  out  AMTWIDTH  rotation offset modulo W; left is positive.
- SC_RegPOINTROT_dir_Out  out  1  ping-pong direction: 0 left, 1 right.
- SC_RegPOINTROT_wrap_OutHigh  out  1  one-cycle pulse on wrap or bounce.

Behaviour:
- Reset: one clock, SC_RegPOINTROT_CLOCK_50; reset SC_RegPOINTROT_RESET_InHigh is asynchronous and active-high.
  - While asserted: data=0, position=0, dir=0, wrap=0, prescaler=0, regardless of clock.
- Priority per edge: clear > load > step.
- Clear: data=DATA_FIXED_INITREGPOINT, position=0, dir=0, prescaler=0.
- Load: data=data_InBUS, position=0, dir=0, prescaler=0.
- Prescaler:
  - Counts 0..prescale_In; tick is asserted when count==prescale_In, and the count returns to 0 on the next edge.
  - Held at 0 when autostep_en_In=0.
  - Runs in mode 00 as well.
- Step event = (step_InLow==0) OR tick.
  - Simultaneous manual step and tick give exactly one step.
  - A tick coinciding with clear/load is consumed.
- Mode 00: step ignored; outputs hold.
- Mode 01:
  - data rotated left by amount.
  - position = (position+amount) mod W.
  - wrap=1 if position+amount ≥ W.
- Mode 10:
  - data rotated right by amount.
  - position = (position-amount) mod W.
  - wrap=1 if amount > position.
- Mode 11, two-state FSM PP_LEFT(dir=0) / PP_RIGHT(dir=1):
  - PP_LEFT, position+amount ≤ W-1: rotate left as in mode 01, no wrap.
  - PP_LEFT, otherwise: bounce cycle. data and position unchanged, dir→1, wrap=1.
  - PP_RIGHT, position ≥ amount: rotate right, no wrap.
  - PP_RIGHT, otherwise: bounce cycle. dir→0, wrap=1.
- amount=0: step has no effect on data or position. No wrap in modes 01/10. In mode 11 PP_LEFT it moves nothing; in PP_RIGHT with position 0 it moves nothing.
- Mode change mid-operation:
  - dir retained; only clear/load/reset return dir to 0.
  - Modes 01/10 do not alter dir.
- Latency:
  - data/position/dir update on the edge following the step event.
  - wrap is registered and high for exactly the cycle the new data is visible; 0 otherwise.

Optional Feature:
- Macro SC_REGPOINTROT_LOGICAL_SHIFT_EN.
- When defined:
  - Adds ports SC_RegPOINTROT_shiftmode_In (in, 1) and SC_RegPOINTROT_fill_In (in, 1).
  - With shiftmode_In=1, modes 01/10/11 perform logical shifts, filling vacated bits with fill_In.
  - Position and wrap rules are unchanged.
- When undefined: ports absent; rotate only.

Decomposition:
- Package sc_regpointrot_pkg: mode encodings (MODE_HOLD, MODE_ROTL, MODE_ROTR, MODE_PINGPONG), FSM state encodings PP_LEFT/PP_RIGHT.
- Sub-module sc_regpointrot_prescaler: counter, tick, synchronous restart input, enable.

Test Plan (W=8):
- Reset held, then clear low 1 cycle → data 00000001, position 0, dir 0, wrap 0.
- Mode 01, amount 3, three manual steps from 00000001:
  - data 00001000, 01000000, 00000010.
  - position 3, 6, 1.
  - wrap pulses only on the third step.
- Load 10000000, mode 10, amount 1, one step → data 01000000, position 7, wrap pulse.
- Mode 11, amount 2, autostep, prescale 3, from clear:
  - A step every 4 cycles.
  - data 00000100, 00010000, 01000000.
  - Then bounce: data held, dir→1, wrap.
  - Then 00010000, 00000100, 00000001.
  - Then bounce: dir→0, wrap.
- Load, step_InLow low and tick in the same cycle → loaded value kept; next tick exactly 4 cycles later.
- Reset asserted between clock edges mid ping-pong → data, position, dir zero immediately; resume from clear reproduces the ping-pong sequence above.
